// File: rtl/types_pkg.sv
// Shared decode types, supported RV32I opcodes and the opcode legality check.
// Pure definitions: no latency, no flow control.
package types_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [1:0]  ALUOp;
        logic [6:0]  Opcode;
        logic        fu_mem;
        logic        fu_alu;
    } decode_data;

    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_I     = 7'h13;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_JALR  = 7'h67;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational decode of one fetch packet into a decode_data record plus illegal flag.
// Zero latency; no flow control of its own.
module decode_comb
    import types_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output decode_data  dec,
    output logic        illegal
);

    logic [31:0] imm;
    logic [1:0]  alu_op;
    logic        fu_mem;
    logic        fu_alu;

    imm_gen u_imm_gen (
        .instr (instr),
        .imm   (imm)
    );

    signal_decoder u_signal_decoder (
        .opcode (instr[6:0]),
        .alu_op (alu_op),
        .fu_mem (fu_mem),
        .fu_alu (fu_alu)
    );

    always_comb begin
        dec.pc     = pc;
        dec.imm    = imm;
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.rd     = instr[11:7];
        dec.ALUOp  = alu_op;
        dec.Opcode = instr[6:0];
        dec.fu_mem = fu_mem;
        dec.fu_alu = fu_alu;
        illegal    = !is_legal_opcode(instr[6:0]);
    end

endmodule

// File: rtl/imm_gen.sv
// Immediate generator: sign-extended immediate for every RV32I format.
// Combinational, no flow control.
module imm_gen
    import types_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = 32'h0;
        case (instr[6:0])
            OP_I, OP_LOAD, OP_JALR: imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:               imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BR:                  imm = {{19{instr[31]}}, instr[31], instr[7],
                                           instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:       imm = {instr[31:12], 12'h0};
            OP_JAL:                 imm = {{11{instr[31]}}, instr[31], instr[19:12],
                                           instr[20], instr[30:21], 1'b0};
            default:                imm = 32'h0;
        endcase
    end

endmodule

// File: rtl/signal_decoder.sv
// Control decoder: ALU operation class and functional-unit steering from the opcode.
// Combinational, no flow control.
module signal_decoder
    import types_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [1:0] alu_op,
    output logic       fu_mem,
    output logic       fu_alu
);

    always_comb begin
        alu_op = ALUOP_ADD;
        fu_mem = 1'b0;
        fu_alu = 1'b0;
        case (opcode)
            OP_R:               begin alu_op = ALUOP_R;  fu_alu = 1'b1; end
            OP_I:               begin alu_op = ALUOP_I;  fu_alu = 1'b1; end
            OP_BR:              begin alu_op = ALUOP_BR; fu_alu = 1'b1; end
            OP_LOAD, OP_STORE:  fu_mem = 1'b1;
            OP_LUI, OP_AUIPC,
            OP_JAL, OP_JALR:    fu_alu = 1'b1;
            default:            ;
        endcase
    end

endmodule

// File: rtl/decode_queue.sv
// Registered decode stage: decodes fetch packets into a DEPTH-entry FIFO; push-to-head latency 1 cycle.
// Backpressure: ready_in depends on occupancy only, so no combinational path from rename to fetch.
module decode_queue
    import types_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [31:0]      instr,
    input  logic [31:0]      pc_in,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic             ready_out,
    output logic             valid_out,
    output decode_data       data_out,
    output logic             illegal_out,
    output logic [PTR_W:0]   count_out
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    decode_data     entry_mem   [DEPTH];
    logic           illegal_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    decode_data dec;
    logic       dec_illegal;
    logic       push;
    logic       pop;

    decode_comb u_decode_comb (
        .instr   (instr),
        .pc      (pc_in),
        .dec     (dec),
        .illegal (dec_illegal)
    );

    assign ready_in    = (count < FULL_CNT);
    assign valid_out   = (count != '0);
    assign count_out   = count;
    assign data_out    = entry_mem[rd_ptr];
    assign illegal_out = illegal_mem[rd_ptr];

    assign push = valid_in && ready_in && !flush && !reset;
    assign pop  = valid_out && ready_out && !flush && !reset;

    // Entry contents survive flush/reset; only pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_mem[wr_ptr]   <= dec;
            illegal_mem[wr_ptr] <= dec_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
